// File: rtl/counter_pkg.sv
// Shared types for the up/down counter block.
//   mode_e      : boundary behaviour selector (2'b11 is reserved and decodes as WRAP)
//   cnt_state_e : RUN while counting, HALT after a ONESHOT boundary
package counter_pkg;

  typedef enum logic [1:0] {
    MODE_WRAP    = 2'b00,
    MODE_SAT     = 2'b01,
    MODE_ONESHOT = 2'b10
  } mode_e;

  typedef enum logic {
    ST_RUN,
    ST_HALT
  } cnt_state_e;

endpackage

// File: rtl/counter_if.sv
// Bus bundle between the counter and whoever drives it.
//   master : drives en, load, data, up_dwn, limit, mode; observes out, tc, halted
//   slave  : the counter side (mirror of master)
interface counter_if #(
  parameter int WIDTH = 8
);
  logic             en;
  logic             load;
  logic [WIDTH-1:0] data;
  logic             up_dwn;
  logic [WIDTH-1:0] limit;
  logic [1:0]       mode;
  logic [WIDTH-1:0] out;
  logic             tc;
  logic             halted;

  modport master (
    output en, load, data, up_dwn, limit, mode,
    input  out, tc, halted
  );

  modport slave (
    input  en, load, data, up_dwn, limit, mode,
    output out, tc, halted
  );
endinterface

// File: rtl/counter_up_dwn_mod.sv
// Parametrised up/down counter over 0..limit with wrap / saturate / one-shot
// boundary handling, a registered terminal-count pulse and a halted flag.
// Ports:
//   clk    : rising-edge clock
//   reset  : asynchronous active-low reset
//   bus    : counter_if.slave (en, load, data, up_dwn, limit, mode in;
//            out, tc, halted out). All outputs are registered.
module counter_up_dwn_mod
  import counter_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic       clk,
  input  logic       reset,
  counter_if.slave   bus
);

  logic [WIDTH-1:0] out_q, out_d;
  logic             tc_q, tc_d;
  cnt_state_e       state_q, state_d;

  // At the terminal value for the current direction.
  logic at_term;
  assign at_term = bus.up_dwn ? (out_q == bus.limit) : (out_q == '0);

  // State/data registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      out_q   <= '0;
      tc_q    <= 1'b0;
      state_q <= ST_RUN;
    end else begin
      out_q   <= out_d;
      tc_q    <= tc_d;
      state_q <= state_d;
    end
  end

  // Next-state: load > enabled step in RUN > hold.
  always_comb begin
    out_d   = out_q;
    tc_d    = 1'b0;
    state_d = state_q;
    if (bus.load) begin
      out_d   = (bus.data > bus.limit) ? bus.limit : bus.data;
      state_d = ST_RUN;
    end else if (bus.en && state_q == ST_RUN) begin
      if (out_q > bus.limit) begin
        // limit was lowered under us: snap to it without a boundary event
        out_d = bus.limit;
      end else if (at_term) begin
        tc_d = 1'b1;
        case (bus.mode)
          MODE_SAT:     out_d = out_q;
          MODE_ONESHOT: state_d = ST_HALT;
          default:      out_d = bus.up_dwn ? '0 : bus.limit; // WRAP and reserved
        endcase
      end else begin
        out_d = bus.up_dwn ? out_q + WIDTH'(1) : out_q - WIDTH'(1);
      end
    end
  end

  // Outputs.
  always_comb begin
    bus.out    = out_q;
    bus.tc     = tc_q;
    bus.halted = (state_q == ST_HALT);
  end

endmodule
